// File: rtl/qacc_if.sv
// Valid/ready stream bundle carrying a single data word.
// The producer uses the master modport and the consumer uses the slave modport.
interface qacc_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/qacc.sv
// Queue accumulator: sums a stream of {eot, data} elements and emits one registered
// {cnt, sum} result per queue, with single-element queues sustaining one result per cycle.
module qacc #(
    parameter int unsigned W_DIN  = 16,
    parameter int unsigned W_ACC  = 32,
    parameter int unsigned W_CNT  = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    qacc_if.slave  din,
    qacc_if.master dout
);

    if ($bits(din.data) != W_DIN + 1) begin : g_bad_din
        $fatal(1, "qacc: din.data width must be W_DIN+1");
    end
    if ($bits(dout.data) != W_CNT + W_ACC) begin : g_bad_dout
        $fatal(1, "qacc: dout.data width must be W_CNT+W_ACC");
    end
    if (W_ACC < W_DIN) begin : g_bad_acc
        $fatal(1, "qacc: W_ACC must be >= W_DIN");
    end

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e                   state_q, state_d;
    logic [W_ACC-1:0]         acc_q, acc_d, acc_n;
    logic [W_CNT-1:0]         cnt_q, cnt_d, cnt_n;
    logic [W_CNT+W_ACC-1:0]   res_q, res_d;
    logic [W_DIN-1:0]         elem;
    logic                     eot;
    logic [W_ACC-1:0]         ext_data;
    logic                     hs_in;

    assign elem = din.data[W_DIN-1:0];
    assign eot  = din.data[W_DIN];

    if (W_ACC > W_DIN) begin : g_ext
        assign ext_data = {{(W_ACC - W_DIN){SIGNED ? elem[W_DIN-1] : 1'b0}}, elem};
    end else begin : g_noext
        assign ext_data = elem;
    end

    assign acc_n = acc_q + ext_data;
    assign cnt_n = cnt_q + 1'b1;

    always_comb begin
        din.ready  = (state_q == StAcc) ? 1'b1 : dout.ready;
        dout.valid = (state_q == StOut);
        dout.data  = res_q;
    end

    assign hs_in = din.valid & din.ready;

    // acc/cnt are cleared when a result is loaded, so an element accepted while the
    // previous result drains naturally starts the next queue from zero.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (hs_in) begin
            if (eot) begin
                res_d   = {cnt_n, acc_n};
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StOut;
            end else begin
                acc_d   = acc_n;
                cnt_d   = cnt_n;
                state_d = StAcc;
            end
        end else if (state_q == StOut && dout.ready) begin
            state_d = StAcc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule
